// File: rtl/enemy_datapath_if.sv
// Strobe/feedback bus between the enemy sprite FSM and its datapath,
// plus the registered pixel stream the datapath drives to the VGA adapter.
interface enemy_datapath_if;
    logic       en_reset;
    logic       loadX;
    logic       loadY;
    logic       load_colour;
    logic       load_black;
    logic       plot;
    logic       en_counter;
    logic       en_delay_counter;
    logic       reset_delay;
    logic [7:0] X;
    logic [6:0] Y;
    logic [3:0] cnt;
    logic [3:0] delay_cnt;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output en_reset, loadX, loadY, load_colour, load_black, plot,
               en_counter, en_delay_counter, reset_delay,
        input  X, Y, cnt, delay_cnt, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  en_reset, loadX, loadY, load_colour, load_black, plot,
               en_counter, en_delay_counter, reset_delay,
        output X, Y, cnt, delay_cnt, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/enemy_datapath.sv
// Enemy sprite datapath: position, colour, pixel/delay counters, column LFSR
// and a one-cycle registered pixel stream for a 160x120 VGA adapter.
module enemy_datapath #(
    parameter logic [7:0] X_INIT       = 8'd80,
    parameter logic [2:0] ENEMY_COLOUR = 3'b100,
    parameter int         DELAY_DIV    = 50000,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic            clock,
    input  logic            resetn,
    enemy_datapath_if.slave io_bus
);
    localparam int            PW         = $clog2(DELAY_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DELAY_DIV - 1);
    localparam logic [6:0]    Y_LAST     = 7'd110;

    logic [7:0]    r_lfsr;
    logic [7:0]    r_x;
    logic [6:0]    r_y;
    logic [3:0]    r_cnt;
    logic [3:0]    r_delay_cnt;
    logic [PW-1:0] r_prescaler;
    logic [2:0]    r_colour;
    logic [7:0]    r_vga_x;
    logic [6:0]    r_vga_y;
    logic [2:0]    r_vga_colour;
    logic          r_vga_plot;

    logic       w_lfsr_fb;
    logic [7:0] w_x_rand;
    logic       w_delay_clear;

    // Taps x^8+x^6+x^5+x^4+1; maximal length, so a non-zero seed never hits 0.
    assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Folding 157..255 down by 100 keeps the whole 4-wide sprite on screen.
    assign w_x_rand      = (r_lfsr < 8'd157) ? r_lfsr : r_lfsr - 8'd100;
    assign w_delay_clear = io_bus.reset_delay | ~io_bus.en_delay_counter;

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_x         <= X_INIT;
            r_y         <= '0;
            r_cnt       <= '0;
            r_delay_cnt <= '0;
            r_prescaler <= '0;
            r_colour    <= '0;
        end else if (io_bus.en_reset) begin
            r_x         <= X_INIT;
            r_y         <= '0;
            r_cnt       <= '0;
            r_delay_cnt <= '0;
            r_prescaler <= '0;
            r_colour    <= '0;
        end else begin
            if (io_bus.loadX)       r_x      <= w_x_rand;
            if (io_bus.loadY)       r_y      <= (r_y == Y_LAST) ? 7'd0 : r_y + 7'd1;
            if (io_bus.en_counter)  r_cnt    <= r_cnt + 4'd1;
            if (io_bus.load_colour) r_colour <= ENEMY_COLOUR;

            // Counting takes precedence over an explicit clear request.
            if (io_bus.en_delay_counter) begin
                if (r_prescaler == PRESC_LAST) begin
                    r_prescaler <= '0;
                    if (r_delay_cnt != 4'd15) r_delay_cnt <= r_delay_cnt + 4'd1;
                end else begin
                    r_prescaler <= r_prescaler + 1'b1;
                end
            end else if (w_delay_clear) begin
                r_prescaler <= '0;
                r_delay_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_x      <= r_x + {6'd0, r_cnt[1:0]};
            r_vga_y      <= r_y + {5'd0, r_cnt[3:2]};
            r_vga_colour <= io_bus.load_black ? 3'b000 : r_colour;
            r_vga_plot   <= io_bus.plot;
        end
    end

    assign io_bus.X          = r_x;
    assign io_bus.Y          = r_y;
    assign io_bus.cnt        = r_cnt;
    assign io_bus.delay_cnt  = r_delay_cnt;
    assign io_bus.vga_x      = r_vga_x;
    assign io_bus.vga_y      = r_vga_y;
    assign io_bus.vga_colour = r_vga_colour;
    assign io_bus.vga_plot   = r_vga_plot;
endmodule

// File: tb/tb_enemy_datapath.sv
// Directed bench for enemy_datapath: reset, draw, erase, delay, respawn, en_reset.
module tb_enemy_datapath;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   y_exp = 0;

    enemy_datapath_if bus ();

    enemy_datapath #(.DELAY_DIV(4)) dut (
        .clock (clock),
        .resetn(resetn),
        .io_bus(bus)
    );

    always #5 clock = ~clock;

    // Reference LFSR, x^8+x^6+x^5+x^4+1, seed A5, free-running out of reset.
    logic [7:0] m_lfsr;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [7:0] map_x(input logic [7:0] v);
        return (v < 8'd157) ? v : v - 8'd100;
    endfunction

    task automatic idle();
        bus.en_reset = 0; bus.loadX = 0; bus.loadY = 0; bus.load_colour = 0;
        bus.load_black = 0; bus.plot = 0; bus.en_counter = 0;
        bus.en_delay_counter = 0; bus.reset_delay = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #12 resetn = 1'b1;
        bus.load_colour = 1; bus.loadY = 1; bus.plot = 1; bus.en_counter = 1;
        repeat (3) tick();
        #3 resetn = 1'b0;
        #1;
        total++; if (bus.X !== 8'd80) begin bad++; $display("FAIL async_x: got %0d want 80", bus.X); end
        total++; if (bus.Y !== 7'd0) begin bad++; $display("FAIL async_y: got %0d want 0", bus.Y); end
        total++; if (bus.cnt !== 4'd0) begin bad++; $display("FAIL async_cnt: got %0d want 0", bus.cnt); end
        total++; if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== 19'd0) begin
            bad++; $display("FAIL async_vga: got x=%0d y=%0d c=%0d p=%0d want all 0",
                            bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot);
        end
        idle();
        #2 resetn = 1'b1;
        repeat (10) tick();
        total++; if (bus.X !== 8'd80) begin bad++; $display("FAIL idle_x: got %0d want 80", bus.X); end
        total++; if (bus.Y !== 7'd0) begin bad++; $display("FAIL idle_y: got %0d want 0", bus.Y); end
        total++; if (bus.delay_cnt !== 4'd0) begin bad++; $display("FAIL idle_delay: got %0d want 0", bus.delay_cnt); end
        total++; if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot} !== {8'd80, 7'd0, 3'd0, 1'b0}) begin
            bad++; $display("FAIL idle_vga: got x=%0d y=%0d c=%0d p=%0d want 80 0 0 0",
                            bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot);
        end
        y_exp = 0;
    endtask

    task automatic test_frame(input bit black, input bit do_loady);
        logic [2:0] c_exp;
        c_exp = black ? 3'b000 : 3'b100;
        if (do_loady) begin
            bus.load_colour = 1; bus.loadY = 1;
            tick();
            idle();
            y_exp++;
        end
        total++; if (bus.Y !== 7'(y_exp)) begin bad++; $display("FAIL frame_y: got %0d want %0d", bus.Y, y_exp); end
        bus.plot = 1; bus.en_counter = 1; bus.load_black = black;
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (bus.vga_x !== 8'(80 + k % 4) || bus.vga_y !== 7'(y_exp + k / 4) ||
                bus.vga_colour !== c_exp || bus.vga_plot !== 1'b1) begin
                bad++;
                $display("FAIL pixel%0d: got (%0d,%0d,%0d,p%0d) want (%0d,%0d,%0d,p1)", k,
                         bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot,
                         80 + k % 4, y_exp + k / 4, c_exp);
            end
        end
        total++; if (bus.cnt !== 4'd0) begin bad++; $display("FAIL cnt_wrap: got %0d want 0", bus.cnt); end
        idle();
        tick();
        total++; if (bus.vga_plot !== 1'b0) begin bad++; $display("FAIL plot_drop: got %0d want 0", bus.vga_plot); end
    endtask

    task automatic test_delay();
        bus.en_delay_counter = 1; bus.reset_delay = 1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 4) begin
                total++; if (bus.delay_cnt !== 4'd1) begin bad++; $display("FAIL delay_4: got %0d want 1", bus.delay_cnt); end
            end
            if (i == 59) begin
                total++; if (bus.delay_cnt !== 4'd14) begin bad++; $display("FAIL delay_59: got %0d want 14", bus.delay_cnt); end
            end
        end
        total++; if (bus.delay_cnt !== 4'd15) begin bad++; $display("FAIL delay_60: got %0d want 15", bus.delay_cnt); end
        repeat (9) tick();
        total++; if (bus.delay_cnt !== 4'd15) begin bad++; $display("FAIL delay_sat: got %0d want 15", bus.delay_cnt); end
        idle();
        tick();
        total++; if (bus.delay_cnt !== 4'd0) begin bad++; $display("FAIL delay_clr: got %0d want 0", bus.delay_cnt); end
    endtask

    task automatic test_respawn();
        logic [7:0] v;
        logic       seen [256];
        int         distinct;
        distinct = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        bus.loadY = 1;
        while (y_exp != 110) begin
            tick();
            y_exp++;
        end
        total++; if (bus.Y !== 7'd110) begin bad++; $display("FAIL y_top: got %0d want 110", bus.Y); end
        bus.loadX = 1;
        v = m_lfsr;
        tick();
        y_exp = 0;
        total++; if (bus.Y !== 7'd0 || bus.X !== map_x(v)) begin
            bad++; $display("FAIL respawn: got X=%0d Y=%0d want X=%0d Y=0", bus.X, bus.Y, map_x(v));
        end
        bus.loadY = 0;
        for (int i = 0; i < 256; i++) begin
            v = m_lfsr;
            tick();
            total++;
            if (bus.X !== map_x(v) || bus.X > 8'd156) begin
                bad++; $display("FAIL rand_x%0d: got %0d want %0d", i, bus.X, map_x(v));
            end
            if (!seen[bus.X]) begin seen[bus.X] = 1'b1; distinct++; end
        end
        total++; if (distinct < 2) begin bad++; $display("FAIL rand_spread: got %0d distinct want >=2", distinct); end
        idle();
    endtask

    task automatic test_en_reset();
        logic [7:0] v;
        bus.load_colour = 1;
        tick();
        idle();
        bus.loadY = 1;
        while (y_exp != 50) begin
            tick();
            y_exp++;
        end
        idle();
        bus.plot = 1; bus.en_counter = 1; bus.en_delay_counter = 1;
        repeat (7) tick();
        total++; if (bus.Y !== 7'd50 || bus.cnt !== 4'd7 || bus.delay_cnt !== 4'd1) begin
            bad++; $display("FAIL pre_enr: got Y=%0d cnt=%0d dly=%0d want 50 7 1", bus.Y, bus.cnt, bus.delay_cnt);
        end
        bus.en_reset = 1; bus.loadX = 1; bus.loadY = 1; bus.load_colour = 1;
        tick();
        y_exp = 0;
        total++; if (bus.X !== 8'd80 || bus.Y !== 7'd0 || bus.cnt !== 4'd0 || bus.delay_cnt !== 4'd0) begin
            bad++; $display("FAIL en_reset: got X=%0d Y=%0d cnt=%0d dly=%0d want 80 0 0 0",
                            bus.X, bus.Y, bus.cnt, bus.delay_cnt);
        end
        idle();
        tick();
        total++; if (bus.vga_colour !== 3'd0 || bus.vga_plot !== 1'b0) begin
            bad++; $display("FAIL enr_colour: got c=%0d p=%0d want 0 0", bus.vga_colour, bus.vga_plot);
        end
        bus.loadX = 1;
        v = m_lfsr;
        tick();
        idle();
        total++; if (bus.X !== map_x(v)) begin bad++; $display("FAIL lfsr_cont: got %0d want %0d", bus.X, map_x(v)); end
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, 1'b1);
        test_frame(1'b1, 1'b0);
        test_delay();
        test_respawn();
        test_en_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
